// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions for the pipelined inverse cipher.
//   Constants : NK, NR, NKB (key words, rounds, block bits)
//   Tables    : SBOX, INV_SBOX (byte b at bits [8b:8b+7]), RCON (r = 1..10)
//   Functions : xtime, gmul, inv_shift_rows, inv_sub_bytes, inv_mix_columns,
//               sub_word, rot_word, rcon_byte, key_step, inv_key_step
// Blocks use ascending bit numbering: bit 0 is the MSB, byte b = [8b:8b+7],
// column c = bytes 4c..4c+3, so byte index = row + 4*col.
package aes_pkg;

  localparam int NK  = 4;
  localparam int NR  = 10;
  localparam int NKB = NK * 32;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [0:79] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  // r counts from 1, matching the round number of the key it produces.
  function automatic logic [7:0] rcon_byte(input int r);
    return RCON[8*(r-1) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Row r is rotated right by r columns.
  function automatic logic [0:NKB-1] inv_shift_rows(input logic [0:NKB-1] s);
    logic [0:NKB-1] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[8*(row + 4*c) +: 8] = s[8*(row + 4*((c - row + 4) % 4)) +: 8];
    return r;
  endfunction

  function automatic logic [0:NKB-1] inv_sub_bytes(input logic [0:NKB-1] s);
    logic [0:NKB-1] r;
    r = '0;
    for (int b = 0; b < 16; b++)
      r[8*b +: 8] = inv_sbox(s[8*b +: 8]);
    return r;
  endfunction

  function automatic logic [0:NKB-1] inv_mix_columns(input logic [0:NKB-1] s);
    logic [0:NKB-1] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[32*c + 8  +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Forward schedule: round key r from round key r-1.
  function automatic logic [0:NKB-1] key_step(input logic [0:NKB-1] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[0:31] ^ sub_word(rot_word(k[96:127])) ^ {rc, 24'h000000};
    n1 = k[32:63] ^ n0;
    n2 = k[64:95] ^ n1;
    n3 = k[96:127] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Inverted schedule: round key r-1 from round key r. Word 3 is recovered
  // first because word 0 needs it through SubWord(RotWord()).
  function automatic logic [0:NKB-1] inv_key_step(input logic [0:NKB-1] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[96:127] ^ k[64:95];
    p2 = k[64:95] ^ k[32:63];
    p1 = k[32:63] ^ k[0:31];
    p0 = k[0:31] ^ sub_word(rot_word(p3)) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/inv_round_stage.sv
// inv_round_stage: one registered decryption stage of the inverse cipher.
//   clk, rst_n   : clock, synchronous active-high clear
//   state        : state entering this inverse round
//   round_key    : round key r carried from the previous stage
//   rcon         : Rcon[r], used to step the key back to r-1
//   valid        : tag travelling with the state
//   next_state   : registered InvShiftRows/InvSubBytes/AddRoundKey(r-1)
//                  [/InvMixColumns unless last]
//   prev_key     : registered round key r-1
//   next_valid   : registered tag
module inv_round_stage
  import aes_pkg::*;
#(
  parameter bit last = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [0:NKB-1] state,
  input  logic [0:NKB-1] round_key,
  input  logic [7:0]     rcon,
  input  logic           valid,
  output logic [0:NKB-1] next_state,
  output logic [0:NKB-1] prev_key,
  output logic           next_valid
);

  logic [0:NKB-1] key_back;
  logic [0:NKB-1] round_out;

  always_comb begin
    key_back  = inv_key_step(round_key, rcon);
    round_out = inv_sub_bytes(inv_shift_rows(state)) ^ key_back;
    if (!last) round_out = inv_mix_columns(round_out);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      next_state <= '0;
      prev_key   <= '0;
      next_valid <= 1'b0;
    end else begin
      next_state <= round_out;
      prev_key   <= key_back;
      next_valid <= valid;
    end
  end

endmodule

// File: rtl/inverse_cipher.sv
// inverse_cipher: fully pipelined AES-128 decryptor, one word per clock,
// every word with its own key, fixed latency of 20 clocks, no backpressure.
//   clk       : clock
//   rst_n     : synchronous clear, active high (asserted = 1)
//   valid_in  : in/key valid this cycle
//   in, key   : ciphertext and cipher key, bit 0 = MSB
//   valid_out : out holds a decrypted word
//   out       : plaintext
// Pipeline: capture register, K1..K10 forward key expansion (ciphertext rides
// along), then D1..D10 inverse rounds that walk the schedule back to w0.
module inverse_cipher
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid_in,
  input  logic [0:NKB-1] in,
  input  logic [0:NKB-1] key,
  output logic           valid_out,
  output logic [0:NKB-1] out
);

  // Inputs are captured first so the word leaves D10 exactly 20 edges after
  // the edge that sampled it.
  logic [0:NKB-1] cap_ct;
  logic [0:NKB-1] cap_key;
  logic           cap_vld;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cap_ct  <= '0;
      cap_key <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_ct  <= in;
      cap_key <= key;
      cap_vld <= valid_in;
    end
  end

  logic [0:NKB-1] k_key [1:NR];
  logic [0:NKB-1] k_ct  [1:NR];
  logic           k_vld [1:NR];

  for (genvar r = 1; r <= NR; r++) begin : g_kexp
    logic [0:NKB-1] src_key;
    logic [0:NKB-1] src_ct;
    logic           src_vld;

    if (r == 1) begin : g_src_cap
      assign src_key = cap_key;
      assign src_ct  = cap_ct;
      assign src_vld = cap_vld;
    end else begin : g_src_prev
      assign src_key = k_key[r-1];
      assign src_ct  = k_ct[r-1];
      assign src_vld = k_vld[r-1];
    end

    always_ff @(posedge clk) begin
      if (rst_n) begin
        k_key[r] <= '0;
        k_ct[r]  <= '0;
        k_vld[r] <= 1'b0;
      end else begin
        k_key[r] <= key_step(src_key, rcon_byte(r));
        k_ct[r]  <= src_ct;
        k_vld[r] <= src_vld;
      end
    end
  end

  logic [0:NKB-1] d_state [1:NR];
  logic [0:NKB-1] d_key   [1:NR-1];
  logic           d_vld   [1:NR];
  // w0 leaves the pipeline at D10; nothing downstream needs it.
  logic [0:NKB-1] last_key_unused;

  for (genvar n = 1; n <= NR; n++) begin : g_dec
    logic [0:NKB-1] st_in;
    logic [0:NKB-1] rk_in;
    logic           v_in;
    logic [0:NKB-1] pk_out;

    if (n == 1) begin : g_in_kexp
      assign st_in = k_ct[NR] ^ k_key[NR];
      assign rk_in = k_key[NR];
      assign v_in  = k_vld[NR];
    end else begin : g_in_prev
      assign st_in = d_state[n-1];
      assign rk_in = d_key[n-1];
      assign v_in  = d_vld[n-1];
    end

    // Stage n holds w(11-n) and steps it back with Rcon[11-n].
    inv_round_stage #(
      .last (n == NR)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .state      (st_in),
      .round_key  (rk_in),
      .rcon       (rcon_byte(NR + 1 - n)),
      .valid      (v_in),
      .next_state (d_state[n]),
      .prev_key   (pk_out),
      .next_valid (d_vld[n])
    );

    if (n < NR) begin : g_key_fwd
      assign d_key[n] = pk_out;
    end else begin : g_key_end
      assign last_key_unused = pk_out;
    end
  end

  assign out       = d_state[NR];
  assign valid_out = d_vld[NR];

endmodule

// File: tb/tb_inverse_cipher.sv
// tb_inverse_cipher: directed and random checks of inverse_cipher against an
// AES-128 encryption model whose S-box is derived from GF(2^8) inversion.
module tb_inverse_cipher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [0:127] in;
  logic [0:127] key;
  logic         valid_out;
  logic [0:127] out;

  always #5 clk = ~clk;

  inverse_cipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .in        (in),
    .key       (key),
    .valid_out (valid_out),
    .out       (out)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic         v;
    logic [0:127] pt;
  } exp_t;

  exp_t       q[$];
  logic [7:0] sb[256];

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] x, p;
    for (int v = 0; v < 256; v++) begin
      x = v[7:0];
      p = 8'h00;
      if (x != 8'h00) begin
        p = 8'h01;
        repeat (254) p = gm(p, x);
      end
      sb[v] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:127] k);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[8*b +: 8] ^ w[b/4][31 - 8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sb[s[b]];
      for (int b = 0; b < 16; b++) t[b] = s[(b%4) + 4*(((b/4) + (b%4)) % 4)];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
        s = t;
      end
      for (int b = 0; b < 16; b++) s[b] ^= w[4*r + b/4][31 - 8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[8*b +: 8] = s[b];
    return res;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive, let the edge sample, then compare the word due now.
  task automatic step(input logic v, input logic [0:127] c, input logic [0:127] k,
                      input logic [0:127] pt, input logic r);
    exp_t e;
    valid_in = v;
    in       = c;
    key      = k;
    rst_n    = r;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      check_bit("reset_valid", valid_out, 1'b0);
      check_blk("reset_out", out, '0);
      q.delete();
      repeat (20) q.push_back('{v: 1'b0, pt: '0});
    end else begin
      q.push_back('{v: v, pt: pt});
      if (q.size() == 21) begin
        e = q.pop_front();
        check_bit("valid_out", valid_out, e.v);
        if (e.v) check_blk("plaintext", out, e.pt);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, rnd128(), rnd128(), '0, 1'b0);
  endtask

  initial begin
    logic [0:127] k, p, c;
    int issued;
    rst_n    = 1'b1;
    valid_in = 1'b0;
    in       = '0;
    key      = '0;
    build_sbox();

    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b1, C1_CT, C1_KEY, C1_PT, 1'b1);

    // FIPS-197 C.1 single word
    step(1'b1, C1_CT, C1_KEY, C1_PT, 1'b0);
    idle(22);

    // all-zero key
    step(1'b1, Z_CT, '0, '0, 1'b0);
    idle(22);

    // back-to-back with different keys
    step(1'b1, C1_CT, C1_KEY, C1_PT, 1'b0);
    step(1'b1, Z_CT, '0, '0, 1'b0);
    idle(22);

    // bubble pattern 1,0,1 with the same vector
    step(1'b1, C1_CT, C1_KEY, C1_PT, 1'b0);
    step(1'b0, C1_CT, C1_KEY, C1_PT, 1'b0);
    step(1'b1, C1_CT, C1_KEY, C1_PT, 1'b0);
    idle(22);

    // reset mid-flight: 5 words, reset at cycle 8, then one C.1 word
    for (int i = 0; i < 5; i++) begin
      k = rnd128();
      p = rnd128();
      step(1'b1, encrypt(p, k), k, p, 1'b0);
    end
    idle(2);
    step(1'b1, C1_CT, C1_KEY, C1_PT, 1'b1);
    step(1'b1, C1_CT, C1_KEY, C1_PT, 1'b0);
    idle(22);

    // random regression with random bubbles
    issued = 0;
    while (issued < 1000) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        k = rnd128();
        p = rnd128();
        c = encrypt(p, k);
        step(1'b1, c, k, p, 1'b0);
        issued++;
      end
    end
    idle(22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
